// File: rtl/generic_fifo_credit_tx.sv
// Credit-based link transmitter feeding a remote FIFO of depth CREDITS.
// Words are pushed only while a credit is held; a flush drains all credits home.
module generic_fifo_credit_tx #(
    parameter  int DATA_WIDTH = 32,
    parameter  int CREDITS    = 8,
    localparam int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  grant_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  credit_i,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic [CNT_WIDTH-1:0]  credit_cnt_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        DONE  = 2'b10,
        BAD   = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   push;
    logic                   full;
    logic                   overflow;

    assign push         = valid_i & grant_o;
    assign full         = (cnt == FULL);
    assign overflow     = credit_i & full & ~push;
    assign credit_cnt_o = cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (flush_i) state_next = DRAIN;
            end
            DRAIN: begin
                if (full && !valid_o) state_next = DONE;
            end
            DONE: begin
                if (!flush_i) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Grant looks only at registered state so credit_i never bypasses.
    always_comb begin
        grant_o      = 1'b0;
        flush_done_o = 1'b0;
        unique case (state)
            RUN:     grant_o = (cnt != '0);
            DRAIN:   grant_o = 1'b0;
            DONE:    flush_done_o = 1'b1;
            default: grant_o = 1'b0;
        endcase
    end

    // A push and a credit in the same cycle cancel out.
    always_comb begin
        cnt_next = cnt;
        if (push && !credit_i) begin
            cnt_next = cnt - ONE;
        end else if (credit_i && !push && !full) begin
            cnt_next = cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= FULL;
            err_o   <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            cnt     <= cnt_next;
            valid_o <= push;
            if (overflow) err_o <= 1'b1;
            if (push) data_o <= data_i;
        end
    end

endmodule
